subpel_row_collector: RTL

Downstream collector for the subpixel interpolation datapath. Each accepted cycle it captures one 8-pixel row from each of the three horizontal FIR outputs (A, B and C positions). It assembles the rows into complete 8-row blocks in two ping-pong banks, then streams each finished block to the consumer over a valid/ready handshake, one 64-bit row per beat. This replaces the unused output-filling stage after the FIR arrays.

---
 rtl/subpel_pkg.sv | 21 ++
 rtl/subpel_row_bank.sv | 45 ++++
 rtl/subpel_row_collector.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/subpel_pkg.sv
// Shared constants and types for the subpixel row collector.
package subpel_pkg;

  localparam int PIXEL_W   = 8;
  localparam int NUM_PIXEL = 8;
  localparam int ROW_W     = PIXEL_W * NUM_PIXEL;

  // Which horizontal FIR output a stored row came from
  typedef enum logic [1:0] {
    POS_A = 2'd0,
    POS_B = 2'd1,
    POS_C = 2'd2
  } pos_t;

  // Read-side FSM state
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/subpel_row_bank.sv
// One ping-pong bank: A/B/C row storage for a full block.
// All three positions are written together at one row index;
// a combinational mux reads back a single (pos, row) entry.
module subpel_row_bank
  import subpel_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int DATA_W   = ROW_W
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(NUM_ROWS)-1:0] wrow,
  input  logic [DATA_W-1:0]           wa,
  input  logic [DATA_W-1:0]           wb,
  input  logic [DATA_W-1:0]           wc,
  input  pos_t                        rpos,
  input  logic [$clog2(NUM_ROWS)-1:0] rrow,
  output logic [DATA_W-1:0]           rdata
);

  logic [DATA_W-1:0] mem_a [NUM_ROWS];
  logic [DATA_W-1:0] mem_b [NUM_ROWS];
  logic [DATA_W-1:0] mem_c [NUM_ROWS];

  // Store one row of each FIR position; contents need no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_a[wrow] <= wa;
      mem_b[wrow] <= wb;
      mem_c[wrow] <= wc;
    end
  end

  // Select the addressed row for the read side
  always_comb begin
    rdata = '0;
    case (rpos)
      POS_A:   rdata = mem_a[rrow];
      POS_B:   rdata = mem_b[rrow];
      POS_C:   rdata = mem_c[rrow];
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/subpel_row_collector.sv
// Collects A/B/C FIR rows into 8-row blocks across two ping-pong banks
// and streams each finished block out one row per beat.
// Optional macro SUBPEL_COLLECT_OVF_EN adds a sticky overflow flag that
// records any row offered while the write bank is full.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on registered state; out_valid and the
// out_* payload stay unchanged while out_valid && !out_ready.
module subpel_row_collector #(
  parameter int NUM_PIXEL = 8,
  parameter int PIXEL_W   = 8,
  parameter int NUM_ROWS  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]   in_a,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]   in_b,
  input  logic [NUM_PIXEL*PIXEL_W-1:0]   in_c,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_PIXEL*PIXEL_W-1:0]   out_data,
  output logic [1:0]                     out_pos,
  output logic [$clog2(NUM_ROWS)-1:0]    out_row,
  output logic                           out_last,
  output logic                           dbg_state
`ifdef SUBPEL_COLLECT_OVF_EN
  ,
  output logic                           overflow
`endif
);

  import subpel_pkg::*;

  localparam int DW = NUM_PIXEL * PIXEL_W;
  localparam int RB = $clog2(NUM_ROWS);
  localparam logic [RB-1:0] ROW_MAX = RB'(NUM_ROWS - 1);

  // Write side
  logic          wbank;
  logic [RB-1:0] wrow;
  logic          wr_acc;
  logic          wr_last;

  // Bank status
  logic [1:0] full_q;
  logic [1:0] set_vec;
  logic [1:0] clr_vec;
  logic [1:0] full_eff;

  // Read side
  rd_state_t     state_q;
  rd_state_t     state_d;
  logic          rbank;
  pos_t          rpos;
  logic [RB-1:0] rrow;
  logic [DW-1:0] out_data_q;
  logic          hs;
  logic          rd_last_hs;

  // Next presented beat
  logic          nxt_bank;
  pos_t          nxt_pos;
  logic [RB-1:0] nxt_row;
  logic          nxt_load;

  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rd_sel;

  assign in_ready = !full_q[wbank];
  assign wr_acc   = in_valid && in_ready;
  assign wr_last  = wr_acc && (wrow == ROW_MAX);

  assign hs         = out_valid && out_ready;
  assign rd_last_hs = hs && out_last;

  assign set_vec  = wr_last ? (wbank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_vec  = rd_last_hs ? (rbank ? 2'b10 : 2'b01) : 2'b00;
  // A bank completing this cycle counts as full so streaming starts with latency 1
  assign full_eff = full_q | set_vec;

  subpel_row_bank #(.NUM_ROWS(NUM_ROWS), .DATA_W(DW)) u_bank0 (
    .clk   (clk),
    .we    (wr_acc && !wbank),
    .wrow  (wrow),
    .wa    (in_a),
    .wb    (in_b),
    .wc    (in_c),
    .rpos  (nxt_pos),
    .rrow  (nxt_row),
    .rdata (rdata0)
  );

  subpel_row_bank #(.NUM_ROWS(NUM_ROWS), .DATA_W(DW)) u_bank1 (
    .clk   (clk),
    .we    (wr_acc && wbank),
    .wrow  (wrow),
    .wa    (in_a),
    .wb    (in_b),
    .wc    (in_c),
    .rpos  (nxt_pos),
    .rrow  (nxt_row),
    .rdata (rdata1)
  );

  assign rd_sel = nxt_bank ? rdata1 : rdata0;

  // Write pointer: advance row on accept, flip bank when a block completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank <= 1'b0;
      wrow  <= '0;
    end else if (wr_acc) begin
      if (wr_last) begin
        wbank <= ~wbank;
        wrow  <= '0;
      end else begin
        wrow <= wrow + 1'b1;
      end
    end
  end

  // Full flags: set by the writer, cleared by the reader's last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 2'b00;
    else     full_q <= (full_q & ~clr_vec) | set_vec;
  end

  // Read FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Read FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (full_eff[rbank]) state_d = ST_STREAM;
      ST_STREAM: if (rd_last_hs)      state_d = full_eff[~rbank] ? ST_STREAM : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Read FSM outputs, decoded from registered state and pointers
  always_comb begin
    out_valid = (state_q == ST_STREAM);
    out_pos   = rpos;
    out_row   = rrow;
    out_last  = out_valid && (rpos == POS_C) && (rrow == ROW_MAX);
    dbg_state = state_q;
  end

  assign out_data = out_data_q;

  // Choose the beat to present next: A rows, then B rows, then C rows
  always_comb begin
    nxt_bank = rbank;
    nxt_pos  = rpos;
    nxt_row  = rrow;
    nxt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_eff[rbank]) begin
          nxt_pos  = POS_A;
          nxt_row  = '0;
          nxt_load = 1'b1;
        end
      end
      ST_STREAM: begin
        if (rd_last_hs) begin
          nxt_bank = ~rbank;
          nxt_pos  = POS_A;
          nxt_row  = '0;
          nxt_load = full_eff[~rbank];
        end else if (hs) begin
          nxt_load = 1'b1;
          if (rrow == ROW_MAX) begin
            nxt_pos = pos_t'(rpos + 2'd1);
            nxt_row = '0;
          end else begin
            nxt_row = rrow + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Read pointers and the registered output row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbank      <= 1'b0;
      rpos       <= POS_A;
      rrow       <= '0;
      out_data_q <= '0;
    end else begin
      rbank <= nxt_bank;
      rpos  <= nxt_pos;
      rrow  <= nxt_row;
      if (nxt_load) out_data_q <= rd_sel;
    end
  end

`ifdef SUBPEL_COLLECT_OVF_EN
  // Sticky record of a row offered while the write bank was full
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
  end
`endif

endmodule
